// File: rtl/hack_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hack_loader_pkg : shared state encoding and sizing for rom_loader    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package hack_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CNT_LO  = 3'd1,
      S_DATA_HI = 3'd2,
      S_DATA_LO = 3'd3,
      S_CHK_HI  = 3'd4,
      S_CHK_LO  = 3'd5,
      S_RUN     = 3'd6,
      S_ERROR   = 3'd7
   } loader_state_e;

   localparam int unsigned ADDR_W_DEFAULT = 15;

   function automatic int unsigned max_words(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   localparam int unsigned MAX_WORDS = max_words(ADDR_W_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/loader_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_timeout : clearable idle counter, flags TIMEOUT_CYCLES reached |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module loader_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned     CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Expiry is flagged one cycle early so the owner acts exactly on the limit edge.
   assign expired = enable && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_loader : UART byte stream -> Hack ROM writes, CPU held in reset   |
// | Optional trailing checksum: ROM_LOADER_CHECKSUM_EN.  Rev 1.0          |
// +----------------------------------------------------------------------+
module rom_loader
   import hack_loader_pkg::*;
#(
   parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [15:0]       rom_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              error,
   output logic              loaded
);
`ifdef ROM_LOADER_CHECKSUM_EN
   localparam loader_state_e S_DONE = S_CHK_HI;
`else
   localparam loader_state_e S_DONE = S_RUN;
`endif
   localparam int unsigned WORD_LIMIT = max_words(ADDR_W);

   loader_state_e     state_q, state_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       count_q, count_d;
   logic [15:0]       index_q, index_d;
   logic              wr_pend_q, wr_pend_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [15:0]       pend_data_q, pend_data_d;
   logic              rom_we_q, rom_we_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [15:0]       rom_wdata_q, rom_wdata_d;
   logic              run_q, run_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              busy_q, busy_d;
   logic              error_q, error_d;
   logic              loaded_q, loaded_d;
`ifdef ROM_LOADER_CHECKSUM_EN
   logic [15:0]       sum_q, sum_d;
`endif

   logic        in_load;
   logic        expired;
   logic [15:0] word_in;

   assign word_in = {hi_q, rx_data};
   assign in_load = (state_q == S_CNT_LO) || (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                    (state_q == S_CHK_HI) || (state_q == S_CHK_LO);

   loader_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (rx_valid),
      .enable  (in_load),
      .expired (expired)
   );

   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      count_d     = count_q;
      index_d     = index_q;
      wr_pend_d   = 1'b0;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      if (rx_valid) begin
         case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
               hi_d    = rx_data;
               state_d = S_CNT_LO;
            end
            S_CNT_LO: begin
               count_d = word_in;
               index_d = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
               if ({16'd0, word_in} > WORD_LIMIT) state_d = S_ERROR;
               else if (word_in == 16'd0)         state_d = S_DONE;
               else                               state_d = S_DATA_HI;
            end
            S_DATA_HI: begin
               hi_d    = rx_data;
               state_d = S_DATA_LO;
            end
            S_DATA_LO: begin
               // The word is parked for one cycle so the ROM write lands a cycle after acceptance.
               wr_pend_d   = 1'b1;
               pend_addr_d = index_q[ADDR_W-1:0];
               pend_data_d = word_in;
               index_d     = index_q + 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
               sum_d       = sum_q + word_in;
`endif
               state_d     = (index_q == count_q - 16'd1) ? S_DONE : S_DATA_HI;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CHK_HI: begin
               hi_d    = rx_data;
               state_d = S_CHK_LO;
            end
            S_CHK_LO: begin
               state_d = (word_in == sum_q) ? S_RUN : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end else if (expired) begin
         state_d = S_ERROR;
      end
   end

   always_comb begin
      rom_we_d    = wr_pend_q;
      rom_addr_d  = wr_pend_q ? pend_addr_q : rom_addr_q;
      rom_wdata_d = wr_pend_q ? pend_data_q : rom_wdata_q;
      busy_d      = in_load;
      error_d     = (state_q == S_ERROR);
      loaded_d    = loaded_q || (state_q == S_RUN);
      run_d       = (state_q == S_RUN);
      // Release the CPU only after a full cycle in RUN, so the final ROM write has retired.
      cpu_reset_d = !(run_q && (state_q == S_RUN));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         hi_q        <= '0;
         count_q     <= '0;
         index_q     <= '0;
         wr_pend_q   <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         rom_we_q    <= 1'b0;
         rom_addr_q  <= '0;
         rom_wdata_q <= '0;
         run_q       <= 1'b0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
         loaded_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         count_q     <= count_d;
         index_q     <= index_d;
         wr_pend_q   <= wr_pend_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         rom_we_q    <= rom_we_d;
         rom_addr_q  <= rom_addr_d;
         rom_wdata_q <= rom_wdata_d;
         run_q       <= run_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         error_q     <= error_d;
         loaded_q    <= loaded_d;
      end
   end

`ifdef ROM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end
`endif

   assign rom_we    = rom_we_q;
   assign rom_addr  = rom_addr_q;
   assign rom_wdata = rom_wdata_q;
   assign cpu_reset = cpu_reset_q;
   assign busy      = busy_q;
   assign error     = error_q;
   assign loaded    = loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rom_loader : self-checking bench for rom_loader                    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_rom_loader;
   localparam int unsigned ADDR_W = 15;
   localparam int unsigned TMO    = 100;
`ifdef ROM_LOADER_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   typedef logic [7:0]  bq_t[$];
   typedef logic [15:0] w16q_t[$];
   typedef logic [31:0] wq_t[$];

   typedef struct {
      logic [15:0]      cnt;
      int               nw;
      logic [2:0][15:0] w;
      logic             e_err;
      logic             e_busy;
      logic             e_cpr;
      logic             e_ld;
   } vec_t;

   logic              clk      = 1'b0;
   logic              reset    = 1'b1;
   logic [7:0]        rx_data  = 8'h00;
   logic              rx_valid = 1'b0;
   logic              rom_we;
   logic [ADDR_W-1:0] rom_addr;
   logic [15:0]       rom_wdata;
   logic              cpu_reset, busy, error, loaded;

   rom_loader #(
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rom_we    (rom_we),
      .rom_addr  (rom_addr),
      .rom_wdata (rom_wdata),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .error     (error),
      .loaded    (loaded)
   );

   always #5 clk = ~clk;

   int  n_cmp = 0;
   int  n_bad = 0;
   wq_t got_q;
   logic prev_we = 1'b0;
   int  we_double = 0;

   function automatic logic [31:0] wr(input int unsigned a, input logic [15:0] d);
      return (32'(a) << 16) | 32'(d);
   endfunction

   // Write monitor: every ROM write observed, plus detection of stretched pulses.
   always @(negedge clk) begin
      if (rom_we) got_q.push_back(wr(32'(rom_addr), rom_wdata));
      if (rom_we && prev_we) we_double++;
      prev_we = rom_we;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference model: word i of the frame lands at address i.
   function automatic wq_t expected_writes(input w16q_t w);
      wq_t e;
      foreach (w[i]) e.push_back(wr(i, w[i]));
      return e;
   endfunction

   function automatic bq_t make_frame(input logic [15:0] cnt, input w16q_t w,
                                      input bit with_chk, input bit bad_chk);
      bq_t         fr;
      logic [15:0] s = 16'h0000;
      fr.push_back(cnt[15:8]);
      fr.push_back(cnt[7:0]);
      foreach (w[i]) begin
         fr.push_back(w[i][15:8]);
         fr.push_back(w[i][7:0]);
         s = s + w[i];
      end
      if (CHK_EN && with_chk) begin
         if (bad_chk) s = s ^ 16'h0100;
         fr.push_back(s[15:8]);
         fr.push_back(s[7:0]);
      end
      return fr;
   endfunction

   task automatic check_writes(input string name, input wq_t exp);
      check({name, "_nwrites"}, got_q.size(), exp.size());
      foreach (exp[i]) begin
         if (i < got_q.size()) check($sformatf("%s_write%0d", name, i), got_q[i], exp[i]);
      end
      got_q.delete();
   endtask

   task automatic send(input bq_t fr, input int max_gap);
      foreach (fr[i]) begin
         int g;
         @(negedge clk);
         rx_data  = fr[i];
         rx_valid = 1'b1;
         g = (i == fr.size() - 1) ? 0 : int'($urandom_range(max_gap, 0));
         if (g > 0) begin
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (g - 1) @(negedge clk);
         end
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      got_q.delete();
   endtask

   task automatic check_flags(input string name, input logic e_err, input logic e_busy,
                              input logic e_cpr, input logic e_ld);
      check({name, "_error"},     error,     e_err);
      check({name, "_busy"},      busy,      e_busy);
      check({name, "_cpu_reset"}, cpu_reset, e_cpr);
      check({name, "_loaded"},    loaded,    e_ld);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  vt[7];
      w16q_t ws;
      bq_t   fr;
      logic  m_loaded;

      vt[0] = '{16'h0002, 2, {16'h0000, 16'hABCD, 16'h1234}, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[1] = '{16'h0000, 0, {16'h0000, 16'h0000, 16'h0000}, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[2] = '{16'h8001, 0, {16'h0000, 16'h0000, 16'h0000}, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[3] = '{16'h8000, 0, {16'h0000, 16'h0000, 16'h0000}, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[4] = '{16'h0001, 1, {16'h0000, 16'h0000, 16'hFFFF}, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[5] = '{16'h0003, 3, {16'h7FFF, 16'h8000, 16'h0001}, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[6] = '{16'hFFFF, 0, {16'h0000, 16'h0000, 16'h0000}, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset values, then a long idle stretch that must not time out.
      do_reset();
      check("rst_rom_we", rom_we, 1'b0);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_rom_wdata", rom_wdata, 16'h0000);
      check_flags("rst", 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (10000) @(negedge clk);
      check_flags("idle10k", 1'b0, 1'b0, 1'b1, 1'b0);

      // Table vectors, each from a fresh reset, bytes back to back.
      for (int v = 0; v < 7; v++) begin
         ws = {};
         for (int k = 0; k < vt[v].nw; k++) ws.push_back(vt[v].w[k]);
         do_reset();
         fr = make_frame(vt[v].cnt, ws, vt[v].nw == int'(vt[v].cnt), 1'b0);
         send(fr, 0);
         repeat (3) @(negedge clk);
         check_flags($sformatf("vec%0d", v), vt[v].e_err, vt[v].e_busy, vt[v].e_cpr, vt[v].e_ld);
         check_writes($sformatf("vec%0d", v), expected_writes(ws));
      end

      // Exact release timing on the reference frame.
      do_reset();
      ws = {16'h1234, 16'hABCD};
      send(make_frame(16'h0002, ws, 1'b1, 1'b0), 0);
      @(negedge clk);
      check("rel_cpu_reset_n1", cpu_reset, 1'b1);
      check("rel_loaded_n1", loaded, 1'b1);
      check("rel_busy_n1", busy, 1'b0);
      @(negedge clk);
      check("rel_cpu_reset_n2", cpu_reset, 1'b0);
      check_writes("rel", expected_writes(ws));

      // Inter-byte timeout mid-word.
      do_reset();
      send('{8'h00, 8'h01, 8'h12}, 0);
      repeat (TMO - 2) @(negedge clk);
      check("tmo_error_early", error, 1'b0);
      check("tmo_busy_early", busy, 1'b1);
      repeat (4) @(negedge clk);
      check_flags("tmo_late", 1'b1, 1'b0, 1'b1, 1'b0);
      check_writes("tmo", '{});

      // A byte arriving on the expiry edge beats the timeout.
      do_reset();
      send('{8'h00, 8'h01, 8'h12}, 0);
      repeat (TMO - 2) @(negedge clk);
      fr = '{8'h34};
      if (CHK_EN) begin
         fr.push_back(8'h12);
         fr.push_back(8'h34);
      end
      send(fr, 0);
      repeat (3) @(negedge clk);
      check_flags("tmo_edge", 1'b0, 1'b0, 1'b0, 1'b1);
      check_writes("tmo_edge", '{wr(0, 16'h1234)});

`ifdef ROM_LOADER_CHECKSUM_EN
      // Wrong checksum: the word is still written, then the load aborts.
      do_reset();
      send('{8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h06}, 0);
      repeat (3) @(negedge clk);
      check_flags("badchk", 1'b1, 1'b0, 1'b1, 1'b0);
      check_writes("badchk", '{wr(0, 16'h0005)});
`endif

      // Reset between the high and low byte of a word after an earlier good load.
      do_reset();
      ws = {16'h1111};
      send(make_frame(16'h0001, ws, 1'b1, 1'b0), 0);
      repeat (3) @(negedge clk);
      check("mid_pre_loaded", loaded, 1'b1);
      check_writes("mid_pre", expected_writes(ws));
      send('{8'h00, 8'h01, 8'h12}, 0);
      reset = 1'b1;
      #1;
      check("mid_rst_rom_we", rom_we, 1'b0);
      check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
      check("mid_rst_rom_wdata", rom_wdata, 16'h0000);
      check_flags("mid_rst", 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_writes("mid_after", '{});
      ws = {16'h7777};
      send(make_frame(16'h0001, ws, 1'b1, 1'b0), 0);
      repeat (3) @(negedge clk);
      check_flags("mid_reload", 1'b0, 1'b0, 1'b0, 1'b1);
      check_writes("mid_reload", expected_writes(ws));

      // Random frames chained without reset, with random inter-byte gaps.
      do_reset();
      m_loaded = 1'b0;
      for (int f = 0; f < 25; f++) begin
         int          kind;
         logic [15:0] cnt;
         bit          bad;
         bit          exp_err;
         kind = int'($urandom_range(0, 9));
         ws   = {};
         if (kind == 0) begin
            cnt     = 16'(32769 + $urandom_range(0, 30000));
            exp_err = 1'b1;
            fr      = make_frame(cnt, ws, 1'b0, 1'b0);
         end else begin
            cnt = 16'($urandom_range(0, 6));
            for (int k = 0; k < int'(cnt); k++) ws.push_back(16'($urandom));
            bad     = CHK_EN && (kind == 1);
            exp_err = bad;
            fr      = make_frame(cnt, ws, 1'b1, bad);
         end
         send(fr, 3);
         repeat (3) @(negedge clk);
         if (!exp_err) m_loaded = 1'b1;
         check_flags($sformatf("rnd%0d", f), exp_err, 1'b0, exp_err, m_loaded);
         check_writes($sformatf("rnd%0d", f), expected_writes(ws));
      end

      check("we_single_cycle", we_double, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
